// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ID->EX register, one-hot ALU, HI/LO and restoring divider.
// Optional single-cycle mult/multu enabled by defining EX_MULT_EN.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    ex_wreg,
  output logic [4:0]              ex_waddr,
  output logic [31:0]             ex_wdata,
  output logic                    ex_opl,
  output logic                    stallreq_for_ex
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } div_state_e;

  logic [ID_TO_EX_WD-1:0] bus_r;

  logic [31:0] pc;
  logic [31:0] inst;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        sel_rf_res;
  logic [31:0] rs;
  logic [31:0] rt;

  logic        ex_stop;
  logic        id_stop;

  assign ex_stop = stall[3];
  assign id_stop = stall[2];

  // ID stopped while EX moves on: EX must take a bubble rather than re-execute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_r <= '0;
    end else if (id_stop && !ex_stop) begin
      bus_r <= '0;
    end else if (!id_stop) begin
      bus_r <= id_to_ex_bus;
    end
  end

  assign pc         = bus_r[158:127];
  assign inst       = bus_r[126:95];
  assign alu_op     = bus_r[94:83];
  assign sel_src1   = bus_r[82:80];
  assign sel_src2   = bus_r[79:76];
  assign ram_en     = bus_r[75];
  assign ram_wen    = bus_r[74:71];
  assign rf_we      = bus_r[70];
  assign rf_waddr   = bus_r[69:65];
  assign sel_rf_res = bus_r[64];
  assign rs         = bus_r[63:32];
  assign rt         = bus_r[31:0];

  // Special-opcode decode
  logic [5:0] func;
  logic       is_special;
  logic       op_mfhi, op_mflo, op_mthi, op_mtlo;
  logic       op_mult, op_multu, op_div, op_divu;

  assign func       = inst[5:0];
  assign is_special = (inst[31:26] == 6'b0);
  assign op_mfhi    = is_special && (func == 6'h10);
  assign op_mthi    = is_special && (func == 6'h11);
  assign op_mflo    = is_special && (func == 6'h12);
  assign op_mtlo    = is_special && (func == 6'h13);
  assign op_mult    = is_special && (func == 6'h18);
  assign op_multu   = is_special && (func == 6'h19);
  assign op_div     = is_special && (func == 6'h1A);
  assign op_divu    = is_special && (func == 6'h1B);

  // ALU operands
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] sa_zext;
  logic [31:0] op1;
  logic [31:0] op2;

  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};
  assign sa_zext  = {27'b0, inst[10:6]};

  assign op1 = ({32{sel_src1[0]}} & rs)
             | ({32{sel_src1[1]}} & pc)
             | ({32{sel_src1[2]}} & sa_zext);

  assign op2 = ({32{sel_src2[0]}} & rt)
             | ({32{sel_src2[1]}} & imm_sext)
             | ({32{sel_src2[2]}} & 32'd8)
             | ({32{sel_src2[3]}} & imm_zext);

  // One-hot ALU: {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
  logic [31:0] add_res, sub_res, slt_res, sltu_res;
  logic [31:0] and_res, nor_res, or_res, xor_res;
  logic [31:0] sll_res, srl_res, sra_res, lui_res;
  logic [31:0] alu_res;

  assign add_res  = op1 + op2;
  assign sub_res  = op1 - op2;
  assign slt_res  = {31'b0, ($signed(op1) < $signed(op2))};
  assign sltu_res = {31'b0, (op1 < op2)};
  assign and_res  = op1 & op2;
  assign nor_res  = ~(op1 | op2);
  assign or_res   = op1 | op2;
  assign xor_res  = op1 ^ op2;
  assign sll_res  = op2 << op1[4:0];
  assign srl_res  = op2 >> op1[4:0];
  assign sra_res  = $signed(op2) >>> op1[4:0];
  assign lui_res  = {op2[15:0], 16'b0};

  assign alu_res = ({32{alu_op[11]}} & add_res)
                 | ({32{alu_op[10]}} & sub_res)
                 | ({32{alu_op[9]}}  & slt_res)
                 | ({32{alu_op[8]}}  & sltu_res)
                 | ({32{alu_op[7]}}  & and_res)
                 | ({32{alu_op[6]}}  & nor_res)
                 | ({32{alu_op[5]}}  & or_res)
                 | ({32{alu_op[4]}}  & xor_res)
                 | ({32{alu_op[3]}}  & sll_res)
                 | ({32{alu_op[2]}}  & srl_res)
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & lui_res);

  // Divider state machine
  div_state_e state, state_nxt;
  logic       div_start;
  logic [4:0] div_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    stallreq_for_ex = 1'b0;
    div_start       = 1'b0;
    case (state)
      S_IDLE: begin
        if (op_div || op_divu) begin
          stallreq_for_ex = 1'b1;
          div_start       = 1'b1;
          state_nxt       = S_RUN;
        end
      end
      S_RUN: begin
        stallreq_for_ex = 1'b1;
        if (div_cnt == 5'd31) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!ex_stop) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Restoring divider datapath on magnitudes; sign fix applied at the end
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [31:0] div_den;
  logic [31:0] div_rs;
  logic        div_neg_q;
  logic        div_neg_r;
  logic        div_zero;
  logic [32:0] div_trial;
  logic        div_fits;
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;

  assign rs_abs    = rs[31] ? (~rs + 32'd1) : rs;
  assign rt_abs    = rt[31] ? (~rt + 32'd1) : rt;
  assign div_trial = {div_rem, div_quot[31]};
  assign div_fits  = (div_trial >= {1'b0, div_den});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_quot  <= '0;
      div_rem   <= '0;
      div_den   <= '0;
      div_rs    <= '0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
      div_zero  <= 1'b0;
      div_cnt   <= '0;
    end else if (div_start) begin
      div_quot  <= op_div ? rs_abs : rs;
      div_den   <= op_div ? rt_abs : rt;
      div_rem   <= '0;
      div_rs    <= rs;
      div_neg_q <= op_div && (rs[31] ^ rt[31]);
      div_neg_r <= op_div && rs[31];
      div_zero  <= (rt == 32'b0);
      div_cnt   <= '0;
    end else if (state == S_RUN) begin
      // remainder stays below the divisor, so the low 32 bits of the difference are exact
      div_rem  <= div_fits ? (div_trial[31:0] - div_den) : div_trial[31:0];
      div_quot <= {div_quot[30:0], div_fits};
      div_cnt  <= div_cnt + 5'd1;
    end
  end

  logic [31:0] div_lo;
  logic [31:0] div_hi;

  always_comb begin
    if (div_zero) begin
      div_lo = '1;
      div_hi = div_rs;
    end else begin
      div_lo = div_neg_q ? (~div_quot + 32'd1) : div_quot;
      div_hi = div_neg_r ? (~div_rem + 32'd1) : div_rem;
    end
  end

`ifdef EX_MULT_EN
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'b0, rs} * {32'b0, rt};
`endif

  // HI/LO registers, written only on the edge the instruction leaves EX
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (!ex_stop) begin
      if (state == S_DONE) begin
        hi_r <= div_hi;
        lo_r <= div_lo;
      end else begin
        if (op_mthi) begin
          hi_r <= rs;
        end
        if (op_mtlo) begin
          lo_r <= rs;
        end
`ifdef EX_MULT_EN
        if (op_mult) begin
          {hi_r, lo_r} <= prod_s;
        end
        if (op_multu) begin
          {hi_r, lo_r} <= prod_u;
        end
`endif
      end
    end
  end

  logic [31:0] ex_result;

  always_comb begin
    if (op_mfhi) begin
      ex_result = hi_r;
    end else if (op_mflo) begin
      ex_result = lo_r;
    end else if (op_mult || op_multu) begin
      ex_result = '0;
    end else begin
      ex_result = alu_res;
    end
  end

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign data_sram_en    = ram_en & ~stallreq_for_ex;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = rt;
  assign ex_wreg         = rf_we;
  assign ex_waddr        = rf_waddr;
  assign ex_wdata        = ex_result;
  assign ex_opl          = ram_en & (ram_wen == 4'b0);

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[STALL_WD-1:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: ALU ops, memory request, HI/LO moves, divider, reset abort.
module tb_ex_stage;

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id_bus;
  logic [75:0]  ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_wreg;
  logic [4:0]   ex_waddr;
  logic [31:0]  ex_wdata;
  logic         ex_opl;
  logic         stallreq_for_ex;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  ex_stage #(
    .ID_TO_EX_WD (159),
    .EX_TO_MEM_WD(76),
    .STALL_WD    (6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .id_to_ex_bus   (id_bus),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .ex_wreg        (ex_wreg),
    .ex_waddr       (ex_waddr),
    .ex_wdata       (ex_wdata),
    .ex_opl         (ex_opl),
    .stallreq_for_ex(stallreq_for_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic ren,
                                      input logic [3:0] rwen, input logic we,
                                      input logic [4:0] wa, input logic sel,
                                      input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ren, rwen, we, wa, sel, rs, rt};
  endfunction

  function automatic logic [31:0] r_inst(input logic [5:0] fn, input logic [4:0] sa);
    return {6'b0, 5'd1, 5'd2, 5'd3, sa, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input string tag, input logic [11:0] op, input logic [2:0] s1,
                     input logic [3:0] s2, input logic [31:0] inst, input logic [31:0] pc,
                     input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] exp);
    id_bus = mk(pc, inst, op, s1, s2, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, rs, rt);
    stall  = 6'b0;
    tick();
    check(tag, ex_wdata, exp);
  endtask

  task automatic read_hilo(input string tag, input logic [5:0] fn, input logic [31:0] exp);
    id_bus = mk(32'h0, r_inst(fn, 5'd0), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0, 32'h0);
    stall  = 6'b0;
    tick();
    check(tag, ex_wdata, exp);
  endtask

  task automatic write_hilo(input logic [5:0] fn, input logic [31:0] val);
    id_bus = mk(32'h0, r_inst(fn, 5'd0), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, val, 32'h0);
    stall  = 6'b0;
    tick();
  endtask

  // Issue a divide with ram_en set so the request gating is visible, hold the pipe while busy.
  task automatic run_div(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input int hold_done);
    int cycles;
    id_bus = mk(32'h0, r_inst(fn, 5'd0), 12'h0, 3'b0, 4'b0, 1'b1, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
    stall  = 6'b0;
    tick();
    stall = 6'b001111;
    check({tag, "_en_gated"}, data_sram_en, 1'b0);
    cycles = 0;
    while (stallreq_for_ex && cycles < 100) begin
      cycles++;
      tick();
    end
    check({tag, "_stall_cycles"}, 76'(cycles), 76'd33);
    check({tag, "_en_done"}, data_sram_en, 1'b1);
    for (int i = 0; i < hold_done; i++) begin
      tick();
      check({tag, "_done_hold"}, stallreq_for_ex, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    rst    = 1'b1;
    stall  = 6'b0;
    id_bus = mk(32'h00400000, r_inst(6'h21, 5'd0), OP_ADD, 3'b001, 4'b0001,
                1'b1, 4'hF, 1'b1, 5'd3, 1'b1, 32'h1234, 32'h5678);
    #3 rst = 1'b0;
    #14;
    check("rst_bus", ex_to_mem_bus, 76'h0);
    check("rst_stallreq", stallreq_for_ex, 1'b0);
    check("rst_sram_en", data_sram_en, 1'b0);
    check("rst_wreg", ex_wreg, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // addu wraps without trapping
    id_bus = mk(32'h00400000, r_inst(6'h21, 5'd0), OP_ADD, 3'b001, 4'b0001,
                1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h7FFF_FFFF, 32'h1);
    tick();
    check("addu_res", ex_wdata, 32'h8000_0000);
    check("addu_wreg", ex_wreg, 1'b1);
    check("addu_waddr", ex_waddr, 5'd3);
    check("addu_bus", ex_to_mem_bus, {32'h00400000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h8000_0000});

    alu("sra", OP_SRA, 3'b100, 4'b0001, r_inst(6'h03, 5'd4), 32'h0, 32'h0, 32'hF000_0000, 32'hFF00_0000);
    alu("srl", OP_SRL, 3'b100, 4'b0001, r_inst(6'h02, 5'd4), 32'h0, 32'h0, 32'hF000_0000, 32'h0F00_0000);
    alu("sll", OP_SLL, 3'b100, 4'b0001, r_inst(6'h00, 5'd4), 32'h0, 32'h0, 32'h0000_00F1, 32'h0000_0F10);
    alu("sub", OP_SUB, 3'b001, 4'b0001, r_inst(6'h23, 5'd0), 32'h0, 32'h5, 32'h7, 32'hFFFF_FFFE);
    alu("slt", OP_SLT, 3'b001, 4'b0001, r_inst(6'h2A, 5'd0), 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h1);
    alu("sltu", OP_SLTU, 3'b001, 4'b0001, r_inst(6'h2B, 5'd0), 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu("and", OP_AND, 3'b001, 4'b0001, r_inst(6'h24, 5'd0), 32'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu("nor", OP_NOR, 3'b001, 4'b0001, r_inst(6'h27, 5'd0), 32'h0, 32'h0, 32'h0000_000F, 32'hFFFF_FFF0);
    alu("or", OP_OR, 3'b001, 4'b0001, r_inst(6'h25, 5'd0), 32'h0, 32'h0F0, 32'h00F, 32'h0FF);
    alu("xor", OP_XOR, 3'b001, 4'b0001, r_inst(6'h26, 5'd0), 32'h0, 32'hFF, 32'h0F, 32'hF0);
    alu("lui", OP_LUI, 3'b000, 4'b1000, {6'h0F, 5'd0, 5'd2, 16'h1234}, 32'h0, 32'h0, 32'h0, 32'h1234_0000);
    alu("jal_pc8", OP_ADD, 3'b010, 4'b0100, {6'h03, 26'h0}, 32'h0040_0010, 32'h0, 32'h0, 32'h0040_0018);
    alu("ori_zext", OP_OR, 3'b001, 4'b1000, {6'h0D, 5'd1, 5'd2, 16'h8000}, 32'h0, 32'h1, 32'h0, 32'h0000_8001);
    alu("addi_sext", OP_ADD, 3'b001, 4'b0010, {6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'h0, 32'h5, 32'h0, 32'h4);
    alu("no_op", 12'h0, 3'b001, 4'b0001, 32'h0, 32'h0, 32'h5, 32'h7, 32'h0);
    alu("no_src", OP_ADD, 3'b000, 4'b0000, r_inst(6'h21, 5'd0), 32'h0, 32'h5, 32'h7, 32'h0);

    // lw: sign-extended offset, read request
    id_bus = mk(32'h0, {6'h23, 5'd1, 5'd2, 16'hFFFC}, OP_ADD, 3'b001, 4'b0010,
                1'b1, 4'h0, 1'b1, 5'd2, 1'b1, 32'h1000, 32'h0);
    stall  = 6'b0;
    tick();
    check("lw_addr", data_sram_addr, 32'h0000_0FFC);
    check("lw_en", data_sram_en, 1'b1);
    check("lw_wen", data_sram_wen, 4'h0);
    check("lw_opl", ex_opl, 1'b1);

    // sw
    id_bus = mk(32'h0, {6'h2B, 5'd1, 5'd2, 16'h0008}, OP_ADD, 3'b001, 4'b0010,
                1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h2000, 32'hDEAD_BEEF);
    tick();
    check("sw_addr", data_sram_addr, 32'h0000_2008);
    check("sw_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    check("sw_wen", data_sram_wen, 4'hF);
    check("sw_opl", ex_opl, 1'b0);

    // ID stopped, EX running: bubble
    stall = 6'b000111;
    tick();
    check("bubble_bus", ex_to_mem_bus, 76'h0);
    check("bubble_en", data_sram_en, 1'b0);

    // EX and ID stopped: hold
    alu("hold_load", OP_ADD, 3'b001, 4'b0001, r_inst(6'h21, 5'd0), 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    stall  = 6'b001111;
    id_bus = mk(32'h0, r_inst(6'h21, 5'd0), OP_ADD, 3'b001, 4'b0001,
                1'b0, 4'h0, 1'b1, 5'd7, 1'b0, 32'h1, 32'h1);
    tick();
    check("hold_res", ex_wdata, 32'h8000_0000);

    write_hilo(6'h11, 32'h1111_1111);
    read_hilo("mthi_mfhi", 6'h10, 32'h1111_1111);
    write_hilo(6'h13, 32'h2222_2222);
    read_hilo("mtlo_mflo", 6'h12, 32'h2222_2222);
    read_hilo("mfhi_kept", 6'h10, 32'h1111_1111);

    run_div("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'h2, 0);
    read_hilo("div_m7_2_lo", 6'h12, 32'hFFFF_FFFD);
    read_hilo("div_m7_2_hi", 6'h10, 32'hFFFF_FFFF);

    run_div("div_100_m7", 6'h1A, 32'd100, 32'hFFFF_FFF9, 0);
    read_hilo("div_100_m7_lo", 6'h12, 32'hFFFF_FFF2);
    read_hilo("div_100_m7_hi", 6'h10, 32'h2);

    run_div("divu_5_0", 6'h1B, 32'h5, 32'h0, 3);
    read_hilo("divu_5_0_lo", 6'h12, 32'hFFFF_FFFF);
    read_hilo("divu_5_0_hi", 6'h10, 32'h5);

    run_div("divu_big", 6'h1B, 32'hFFFF_FFFF, 32'h10, 0);
    read_hilo("divu_big_lo", 6'h12, 32'h0FFF_FFFF);
    read_hilo("divu_big_hi", 6'h10, 32'hF);

    // Reset during the tenth RUN cycle
    id_bus = mk(32'h0, r_inst(6'h1A, 5'd0), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd3);
    stall  = 6'b0;
    tick();
    stall = 6'b001111;
    repeat (10) tick();
    check("abort_busy", stallreq_for_ex, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_stallreq", stallreq_for_ex, 1'b0);
    check("abort_bus", ex_to_mem_bus, 76'h0);
    @(negedge clk);
    rst = 1'b1;
    read_hilo("abort_hi", 6'h10, 32'h0);
    read_hilo("abort_lo", 6'h12, 32'h0);

    // mult -2*3
    write_hilo(6'h11, 32'hAAAA_0000);
    write_hilo(6'h13, 32'h0000_5555);
    id_bus = mk(32'h0, r_inst(6'h18, 5'd0), OP_ADD, 3'b001, 4'b0001,
                1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'hFFFF_FFFE, 32'h3);
    stall  = 6'b0;
    tick();
    check("mult_res", ex_wdata, 32'h0);
    check("mult_nostall", stallreq_for_ex, 1'b0);
`ifdef EX_MULT_EN
    exp_hi = 32'hFFFF_FFFF;
    exp_lo = 32'hFFFF_FFFA;
`else
    exp_hi = 32'hAAAA_0000;
    exp_lo = 32'h0000_5555;
`endif
    read_hilo("mult_hi", 6'h10, exp_hi);
    read_hilo("mult_lo", 6'h12, exp_lo);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
